// File: rtl/cga_pkg.sv
// Shared slot-phase constants, arbiter state encoding and the CPU grant-window helper
// for the CGA VRAM sequencer.
package cga_pkg;

  localparam logic [4:0] P_CHAR    = 5'd0;
  localparam logic [4:0] P_ATT     = 5'd2;
  localparam logic [4:0] P_ROM     = 5'd4;
  localparam logic [4:0] P_CPU_MIN = 5'd6;

  typedef enum logic [1:0] {
    DISP,
    CPU_ADDR,
    CPU_WAIT,
    CPU_DONE
  } seq_state_e;

  // A CPU access granted at phase p must have its ack land no later than the slot's last phase.
  function automatic logic cpu_window(input logic [4:0] p, input logic [4:0] p_last,
                                      input logic video_en, input logic [4:0] lat);
    logic fits;
    fits = (p <= p_last - lat);
    return video_en ? (fits && (p >= P_CPU_MIN)) : fits;
  endfunction

endpackage

// File: rtl/cga_slot_timer.sv
// Free-running clk_seq counter, slot-length latch and display strobe phase decode.
module cga_slot_timer
  import cga_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hres_i,
  input  logic       video_en_i,
  output logic [4:0] clk_seq_o,
  output logic [4:0] phase_o,
  output logic [4:0] phase_last_o,
  output logic       hres_o,
  output logic       read_char_o,
  output logic       read_att_o,
  output logic       charrom_read_o,
  output logic       disp_pipeline_o
);

  localparam logic [4:0] LAT = 5'(RAM_LAT);

  logic [4:0] seq_q, seq_d;
  logic       hres_q, hres_d;

  // Slot length only changes on a clk_seq wrap so a slot is never cut short.
  always_comb begin
    seq_d  = seq_q + 5'd1;
    hres_d = (seq_q == 5'd0) ? hres_i : hres_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q  <= 5'd0;
      hres_q <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      hres_q <= hres_d;
    end
  end

  assign clk_seq_o       = seq_q;
  assign hres_o          = hres_q;
  assign phase_o         = hres_q ? {1'b0, seq_q[3:0]} : seq_q;
  assign phase_last_o    = hres_q ? 5'd15 : 5'd31;
  assign read_char_o     = video_en_i && (phase_o == P_CHAR + LAT);
  assign read_att_o      = video_en_i && (phase_o == P_ATT + LAT);
  assign charrom_read_o  = video_en_i && (phase_o == P_ROM);
  assign disp_pipeline_o = (phase_o == phase_last_o);

endmodule

// File: rtl/cga_vram_sequencer.sv
// CGA character-slot sequencer and single-port VRAM arbiter (display fetches vs ISA CPU).
// Optional feature macro: CGA_SNOW_EN (grant CPU at any phase in hres text mode, causing snow).
module cga_vram_sequencer
  import cga_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hres_mode,
  input  logic              grph_mode,
  input  logic              video_enabled,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [4:0]        clk_seq,
  output logic              crtc_adv,
  output logic              vram_read_char,
  output logic              vram_read_att,
  output logic              charrom_read,
  output logic              disp_pipeline,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait
);

  localparam logic [4:0] LAT = 5'(RAM_LAT);

  logic [4:0] phase, phase_last, next_phase;
  logic       hres_l, t_char, t_att, t_rom, t_pipe;
  logic       grant_ok;

  seq_state_e state_q, state_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cpu_owns_port, we_c, ack_c;

  cga_slot_timer #(.RAM_LAT(RAM_LAT)) u_timer (
    .clk            (clk),
    .reset          (reset),
    .hres_i         (hres_mode),
    .video_en_i     (video_enabled),
    .clk_seq_o      (clk_seq),
    .phase_o        (phase),
    .phase_last_o   (phase_last),
    .hres_o         (hres_l),
    .read_char_o    (t_char),
    .read_att_o     (t_att),
    .charrom_read_o (t_rom),
    .disp_pipeline_o(t_pipe)
  );

  // Grants are registered: the decision is made one cycle ahead against the next phase.
  assign next_phase = t_pipe ? 5'd0 : phase + 5'd1;

`ifdef CGA_SNOW_EN
  assign grant_ok = cpu_window(next_phase, phase_last, video_enabled, LAT) ||
                    (hres_l && !grph_mode);
`else
  logic [1:0] unused_snow;
  assign unused_snow = {grph_mode, hres_l};
  assign grant_ok    = cpu_window(next_phase, phase_last, video_enabled, LAT);
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    cpu_owns_port = 1'b0;
    we_c          = 1'b0;
    ack_c         = 1'b0;
    unique case (state_q)
      DISP: if (cpu_req && grant_ok) state_d = CPU_ADDR;
      CPU_ADDR: begin
        cpu_owns_port = 1'b1;
        we_c          = cpu_we;
        state_d       = (cpu_we || RAM_LAT == 1) ? CPU_DONE : CPU_WAIT;
      end
      CPU_WAIT: begin
        cpu_owns_port = 1'b1;
        state_d       = CPU_DONE;
      end
      CPU_DONE: begin
        ack_c   = 1'b1;
        if (!cpu_we) rdata_d = vram_rdata;
        state_d = DISP;
      end
      default: state_d = DISP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DISP;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are gated by reset so an access in flight is cut off in the cycle reset rises.
  assign vram_addr      = reset         ? '0 :
                          cpu_owns_port ? cpu_addr :
                          (phase < P_ATT) ? disp_addr : (disp_addr | ADDR_W'(1));
  assign vram_we        = !reset && we_c;
  assign vram_wdata     = cpu_wdata;
  assign vram_read_char = !reset && t_char;
  assign vram_read_att  = !reset && t_att;
  assign charrom_read   = !reset && t_rom;
  assign disp_pipeline  = !reset && t_pipe;
  assign crtc_adv       = !reset && t_pipe;
  assign cpu_ack        = !reset && ack_c;
  assign cpu_rdata      = (!reset && ack_c && !cpu_we) ? vram_rdata : rdata_q;
  assign cpu_wait       = !reset && cpu_req && !ack_c;

endmodule

// File: tb/tb_cga_vram_sequencer.sv
// Directed bench for cga_vram_sequencer (ADDR_W=14, RAM_LAT=1) with a 1-cycle VRAM model.
module tb_cga_vram_sequencer;

  logic        clk = 1'b0;
  logic        reset, hres_mode, grph_mode, video_enabled;
  logic [13:0] disp_addr, cpu_addr, vram_addr;
  logic [4:0]  clk_seq;
  logic        crtc_adv, vram_read_char, vram_read_att, charrom_read, disp_pipeline;
  logic        vram_we, cpu_req, cpu_we, cpu_ack, cpu_wait;
  logic [7:0]  vram_wdata, vram_rdata, cpu_wdata, cpu_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cga_vram_sequencer #(.ADDR_W(14), .RAM_LAT(1)) dut (
    .clk(clk), .reset(reset), .hres_mode(hres_mode), .grph_mode(grph_mode),
    .video_enabled(video_enabled), .disp_addr(disp_addr), .clk_seq(clk_seq),
    .crtc_adv(crtc_adv), .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
    .charrom_read(charrom_read), .disp_pipeline(disp_pipeline), .vram_addr(vram_addr),
    .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait)
  );

  // Write-first synchronous VRAM with one cycle of read latency; cleared by reset.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h301] <= 8'hC3;
      vram_rdata   <= 8'h00;
    end else begin
      if (vram_we) mem[vram_addr[9:0]] <= vram_wdata;
      vram_rdata <= vram_we ? vram_wdata : mem[vram_addr[9:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_seq(input logic [4:0] s);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (clk_seq == s) return;
    end
    tests++;
    fails++;
    $display("FAIL wait_seq: clk_seq never reached %0d", s);
  endtask

  // Raise a request at clk_seq==raise and follow it to its ack.
  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] wd,
                            input logic [4:0] raise, output logic [4:0] g, output logic [4:0] k,
                            output logic [7:0] rd, output logic [7:0] att, output logic done);
    logic granted;
    granted = 1'b0;
    done    = 1'b0;
    g = 5'h1f; k = 5'h1f; rd = 8'h00; att = 8'h00;
    wait_seq(raise);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!granted && vram_addr == a) begin
        granted = 1'b1;
        g = clk_seq;
      end
      if (vram_read_att) att = vram_rdata;
      if (cpu_ack) begin
        k = clk_seq;
        rd = cpu_rdata;
        done = 1'b1;
        cpu_req = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  seq;
    logic [4:0]  strb;  // {read_char, read_att, charrom, disp_pipeline, crtc_adv}
    logic [13:0] addr;
  } vec_t;

  vec_t vecs[12];
  logic [4:0] g, k;
  logic [7:0] rd, att;
  logic       done;
  logic [4:0] grants[12];
  logic [4:0] exp_grants[10];
  logic [4:0] pulses[4];
  int n, strobes, pipes, bad_rd, acks;

  initial begin
    vecs[0]  = '{5'd0,  5'b00000, 14'h0300};
    vecs[1]  = '{5'd1,  5'b10000, 14'h0300};
    vecs[2]  = '{5'd2,  5'b00000, 14'h0301};
    vecs[3]  = '{5'd3,  5'b01000, 14'h0301};
    vecs[4]  = '{5'd4,  5'b00100, 14'h0301};
    vecs[5]  = '{5'd5,  5'b00000, 14'h0301};
    vecs[6]  = '{5'd14, 5'b00000, 14'h0301};
    vecs[7]  = '{5'd15, 5'b00011, 14'h0301};
    vecs[8]  = '{5'd16, 5'b00000, 14'h0300};
    vecs[9]  = '{5'd17, 5'b10000, 14'h0300};
    vecs[10] = '{5'd19, 5'b01000, 14'h0301};
    vecs[11] = '{5'd31, 5'b00011, 14'h0301};
    exp_grants = '{5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd16, 5'd19, 5'd22, 5'd25, 5'd28};

    reset = 1'b1; hres_mode = 1'b1; grph_mode = 1'b1; video_enabled = 1'b1;
    disp_addr = 14'h0300; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'h00;

    // Reset state, with a pending request that must not show as wait.
    @(negedge clk); @(negedge clk);
    check("rst_clk_seq", clk_seq, 0);
    check("rst_strobes", {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_adv}, 0);
    check("rst_vram_addr", vram_addr, 0);
    check("rst_we_ack_wait", {vram_we, cpu_ack, cpu_wait}, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    cpu_req = 1'b0;
    reset = 1'b0;

    // Display schedule, hres=1: period 16 strobes.
    foreach (vecs[i]) begin
      wait_seq(vecs[i].seq);
      check($sformatf("sched_strb_seq%0d", vecs[i].seq),
            {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_adv}, vecs[i].strb);
      check($sformatf("sched_addr_seq%0d", vecs[i].seq), vram_addr, vecs[i].addr);
    end

    // Lores write raised at p=1: granted p=6, acked p=7.
    hres_mode = 1'b0;
    wait_seq(5'd0);
    cpu_access(1'b1, 14'h0100, 8'h41, 5'd1, g, k, rd, att, done);
    check("wr_done", done, 1);
    check("wr_grant_seq", g, 6);
    check("wr_ack_seq", k, 7);

    // Hres read raised at p=13 -> grant 14, ack 15; raised at p=15 -> waits to p=6.
    hres_mode = 1'b1;
    wait_seq(5'd0);
    cpu_access(1'b0, 14'h0100, 8'h00, 5'd13, g, k, rd, att, done);
    check("rd13_done", done, 1);
    check("rd13_grant_seq", g, 14);
    check("rd13_ack_seq", k, 15);
    check("rd13_rdata", rd, 8'h41);
    cpu_access(1'b0, 14'h0100, 8'h00, 5'd15, g, k, rd, att, done);
    check("rd15_grant_seq", g, 22);
    check("rd15_ack_seq", k, 23);
    check("rd15_rdata", rd, 8'h41);
    check("rdata_held", cpu_rdata, 8'h41);

    // Video off, back-to-back reads: every third cycle, never at phase 15.
    video_enabled = 1'b0;
    wait_seq(5'd0);
    wait_seq(5'd31);
    cpu_we = 1'b0; cpu_addr = 14'h0100; cpu_req = 1'b1;
    n = 0; strobes = 0; pipes = 0; bad_rd = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (vram_addr == 14'h0100 && n < 12) begin
        grants[n] = clk_seq;
        n++;
      end
      if (vram_read_char || vram_read_att || charrom_read) strobes++;
      if (disp_pipeline) pipes++;
      if (cpu_ack && cpu_rdata != 8'h41) bad_rd++;
      cpu_req = !cpu_ack;
    end
    cpu_req = 1'b0;
    check("b2b_grant_count", n, 10);
    for (int i = 0; i < 10; i++) check($sformatf("b2b_grant%0d", i), grants[i], exp_grants[i]);
    check("b2b_bad_rdata", bad_rd, 0);
    check("b2b_display_strobes", strobes, 0);
    check("b2b_pipeline_pulses", pipes, 2);
    video_enabled = 1'b1;

    // hres dropped at clk_seq=5: period 16 continues until the next wrap.
    wait_seq(5'd5);
    hres_mode = 1'b0;
    n = 0;
    for (int i = 0; i < 58; i++) begin
      @(negedge clk);
      if (disp_pipeline && n < 4) begin
        pulses[n] = clk_seq;
        n++;
      end
    end
    check("hres_pulse_count", n, 3);
    check("hres_pulse0", pulses[0], 15);
    check("hres_pulse1", pulses[1], 31);
    check("hres_pulse2", pulses[2], 31);

    // Reset during the write cycle: we drops at once, no ack afterwards, byte not written.
    wait_seq(5'd1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 8'h77;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vram_we) begin
        done = 1'b1;
        break;
      end
    end
    check("rstw_we_seen", done, 1);
    check("rstw_we_seq", clk_seq, 6);
    reset = 1'b1;
    #1;
    check("rstw_we_forced", vram_we, 0);
    cpu_req = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    check("rstw_no_ack", acks, 0);
    cpu_access(1'b0, 14'h0200, 8'h00, 5'd2, g, k, rd, att, done);
    check("rstw_grant_seq", g, 6);
    check("rstw_not_written", rd, 8'h00);

    // Hres text write raised at p=1: snow vs strict window.
    hres_mode = 1'b1; grph_mode = 1'b0;
    wait_seq(5'd0);
    cpu_access(1'b1, 14'h0140, 8'h99, 5'd1, g, k, rd, att, done);
    check("t6_done", done, 1);
`ifdef CGA_SNOW_EN
    check("snow_grant_seq", g, 2);
    check("snow_ack_seq", k, 3);
    check("snow_att_data", att, 8'h99);
`else
    check("strict_grant_seq", g, 6);
    check("strict_ack_seq", k, 7);
    check("strict_att_data", att, 8'hC3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
